// File: rtl/nids_demo_pkg.sv
// Shared types and constants for the NIDS demo sequencer: FSM states, mode codes,
// seven-segment glyphs and the stored stimulus table.
package nids_demo_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        GAP         = 2'd1,
        ISSUE       = 2'd2,
        WAIT_RESULT = 2'd3
    } state_t;

    localparam logic [1:0] MODE_CONT  = 2'd0;
    localparam logic [1:0] MODE_STEP  = 2'd1;
    localparam logic [1:0] MODE_BURST = 2'd2;

    // Active-low segments, bit order gfedcba.
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    localparam logic [15:0][6:0] SEG_LUT = {SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
                                            SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};

    localparam int N_PATTERNS_MAX = 8;
    localparam int N_FEAT_TBL     = 28;
    localparam int TBL_IW         = $clog2(N_PATTERNS_MAX);

    typedef logic [N_FEAT_TBL-1:0][31:0] tbl_vec_t;
    typedef tbl_vec_t [N_PATTERNS_MAX-1:0] tbl_t;

    // Entry 0 is benign, entry 1 the known attack; higher entries carry a tagged ramp.
    function automatic tbl_t build_table();
        tbl_t t;
        t = '0;
        t[1][2] = 32'h0000_6f00;
        t[1][3] = 32'h0000_cb00;
        t[1][4] = 32'h0000_b500;
        t[1][5] = 32'h0015_4a00;
        for (int p = 2; p < N_PATTERNS_MAX; p++)
            for (int f = 0; f < N_FEAT_TBL; f++)
                t[p][f] = {4'(p), 12'h000, 8'hC0, 8'(f)};
        return t;
    endfunction

    localparam tbl_t PATTERN_TABLE = build_table();

endpackage

// File: rtl/nids_demo_sequencer_if.sv
// Packet issue / result handshake between the sequencer and the NIDS core.
interface nids_demo_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int N_FEATURES = 28
);
    logic [N_FEATURES-1:0][DATA_WIDTH-1:0] pkt_features;
    logic                                  pkt_valid;
    logic                                  core_valid;
    logic                                  core_attack;
    logic [DATA_WIDTH-1:0]                 core_major;
    logic [DATA_WIDTH-1:0]                 core_minor;

    modport master (output pkt_features, pkt_valid,
                    input  core_valid, core_attack, core_major, core_minor);
    modport slave  (input  pkt_features, pkt_valid,
                    output core_valid, core_attack, core_major, core_minor);
endinterface

// File: rtl/hex7seg_decoder.sv
// Nibble to active-low seven-segment glyph.
module hex7seg_decoder
    import nids_demo_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = SEG_LUT[nibble];
endmodule

// File: rtl/nids_demo_sequencer.sv
// Replays stored feature vectors into the NIDS core one packet at a time, captures
// each result, counts attacks and drives the seven-segment display.
module nids_demo_sequencer
    import nids_demo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N_FEATURES = 28,
    parameter int N_PATTERNS = 4,
    parameter int PERIOD     = 256,
    parameter int TIMEOUT    = 1024,
    parameter int N_HEX      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic                 step,
    input  logic [1:0]           disp_sel,
    nids_demo_sequencer_if.master core_if,
    output logic                 attack_led,
    output logic [15:0]          attack_count,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [7*N_HEX-1:0]   hex
);
    localparam int IDX_W = (N_PATTERNS > 1) ? $clog2(N_PATTERNS) : 1;
    localparam int GAP_W = $clog2(PERIOD);
    localparam int TO_W  = $clog2(TIMEOUT);
    localparam int DW    = 4 * N_HEX;

    state_t                                state, state_next;
    logic [IDX_W-1:0]                      idx, idx_inc;
    logic [GAP_W-1:0]                      gap_cnt;
    logic [TO_W-1:0]                       to_cnt;
    logic [DW-1:0]                         major_q, minor_q, disp_val;
    logic                                  step_q, step_rise, take, to_hit, pkt_done;
    logic                                  idx_last, burst_start;
    tbl_vec_t                              row;
    logic [N_FEATURES-1:0][DATA_WIDTH-1:0] feat_next;

    assign step_rise = step & ~step_q;
    assign idx_last  = (idx == IDX_W'(N_PATTERNS - 1));
    assign idx_inc   = idx_last ? '0 : idx + IDX_W'(1);
    // A result arriving on the timeout cycle wins over the timeout.
    assign take      = (state == WAIT_RESULT) && core_if.core_valid;
    assign to_hit    = (state == WAIT_RESULT) && !core_if.core_valid &&
                       (to_cnt == TO_W'(TIMEOUT - 1));
    assign pkt_done  = take | to_hit;
    assign busy      = (state != IDLE);
    assign row       = PATTERN_TABLE[TBL_IW'(idx)];

    for (genvar f = 0; f < N_FEATURES; f++) begin : g_feat
        if (f < N_FEAT_TBL) begin : g_tbl
            assign feat_next[f] = DATA_WIDTH'(row[f]);
        end else begin : g_pad
            assign feat_next[f] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        burst_start = 1'b0;
        case (state)
            IDLE: if (enable) begin
                if (mode == MODE_STEP) begin
                    if (step_rise) state_next = ISSUE;
                end else if (mode == MODE_BURST) begin
                    if (step_rise) begin
                        state_next  = GAP;
                        burst_start = 1'b1;
                    end
                end else begin
                    state_next = GAP;
                end
            end
            GAP: begin
                if (!enable)                              state_next = IDLE;
                else if (gap_cnt == GAP_W'(PERIOD - 2))   state_next = ISSUE;
            end
            ISSUE: state_next = WAIT_RESULT;
            WAIT_RESULT: if (pkt_done) begin
                if (mode == MODE_STEP || (mode == MODE_BURST && idx_last) || !enable)
                    state_next = IDLE;
                else
                    state_next = GAP;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q               <= 1'b0;
            idx                  <= '0;
            gap_cnt              <= '0;
            to_cnt               <= '0;
            core_if.pkt_valid    <= 1'b0;
            core_if.pkt_features <= '0;
            major_q              <= '0;
            minor_q              <= '0;
            attack_led           <= 1'b0;
            attack_count         <= '0;
            timeout_err          <= 1'b0;
        end else begin
            step_q            <= step;
            core_if.pkt_valid <= (state_next == ISSUE);
            if (state_next == ISSUE) core_if.pkt_features <= feat_next;
            gap_cnt <= (state == GAP && state_next == GAP) ? gap_cnt + GAP_W'(1) : '0;
            to_cnt  <= (state == WAIT_RESULT && state_next == WAIT_RESULT) ? to_cnt + TO_W'(1) : '0;
            if (burst_start)   idx <= '0;
            else if (pkt_done) idx <= idx_inc;
            if (take) begin
                major_q    <= core_if.core_major[DW-1:0];
                minor_q    <= core_if.core_minor[DW-1:0];
                attack_led <= core_if.core_attack;
                if (core_if.core_attack && attack_count != 16'hFFFF)
                    attack_count <= attack_count + 16'd1;
            end
            if (to_hit) timeout_err <= 1'b1;
        end
    end

    always_comb begin
        disp_val = '0;
        case (disp_sel)
            2'd0:    disp_val = major_q;
            2'd1:    disp_val = minor_q;
            2'd2:    disp_val = DW'(attack_count);
            default: disp_val = DW'({idx, state, timeout_err});
        endcase
    end

    for (genvar k = 0; k < N_HEX; k++) begin : g_hex
        hex7seg_decoder u_dec (
            .nibble (disp_val[4*k +: 4]),
            .seg    (hex[7*k +: 7])
        );
    end

endmodule

// File: tb/tb_nids_demo_sequencer.sv
// Self-checking bench for nids_demo_sequencer: a responding core model, a feature
// scoreboard on every issue, table-driven display/step checks and corner sequences.
module tb_nids_demo_sequencer;
    localparam int DW = 32, NF = 28, NP = 4, PER = 8, TO = 16, NH = 4;
    typedef logic [NF-1:0][DW-1:0] feat_t;

    typedef struct {
        logic [1:0]  sel;
        logic [27:0] exp_hex;
    } disp_vec_t;

    typedef struct {
        logic        atk;
        logic [31:0] maj;
        logic [31:0] mnr;
        logic        exp_led;
        logic [15:0] exp_cnt;
    } step_vec_t;

    logic          clk = 1'b0, rst_n = 1'b0, enable = 1'b0, step = 1'b0;
    logic [1:0]    mode = 2'd0, disp_sel = 2'd0;
    logic          attack_led, busy, timeout_err;
    logic [15:0]   attack_count;
    logic [7*NH-1:0] hex;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, n_issue = 0, last_issue_cyc = 0;
    int core_lat = 3, rsp_cnt = 0, m_idx = 0;
    bit core_silent = 1'b0;
    feat_t exp_q[$];

    nids_demo_sequencer_if #(.DATA_WIDTH(DW), .N_FEATURES(NF)) cif ();

    nids_demo_sequencer #(
        .DATA_WIDTH(DW), .N_FEATURES(NF), .N_PATTERNS(NP),
        .PERIOD(PER), .TIMEOUT(TO), .N_HEX(NH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .step(step),
        .disp_sel(disp_sel), .core_if(cif), .attack_led(attack_led),
        .attack_count(attack_count), .busy(busy), .timeout_err(timeout_err), .hex(hex)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [27:0] hexw(input logic [15:0] v);
        return {seg(v[15:12]), seg(v[11:8]), seg(v[7:4]), seg(v[3:0])};
    endfunction

    function automatic feat_t pat(input int p);
        feat_t v = '0;
        if (p == 1) begin
            v[2] = 32'h6f00; v[3] = 32'hcb00; v[4] = 32'hb500; v[5] = 32'h154a00;
        end else if (p >= 2) begin
            for (int f = 0; f < NF; f++) v[f] = (32'(p) << 28) | 32'h0000_C000 | 32'(f);
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_issue();
        exp_q.push_back(pat(m_idx));
        m_idx = (m_idx == NP - 1) ? 0 : m_idx + 1;
    endtask

    task automatic pulse_step();
        @(posedge clk); #1 step = 1'b1;
        @(posedge clk); #1 step = 1'b0;
    endtask

    task automatic wait_issues(input int target);
        int i = 0;
        while (n_issue < target && i < 500) begin @(negedge clk); i++; end
        chk("wait_issues", 32'(n_issue >= target), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int i = 0;
        @(negedge clk);
        while (busy && i < 500) begin @(negedge clk); i++; end
        chk(name, 32'(busy), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"},     32'(busy), 32'd0);
        chk({tag, "_pkt_valid"}, 32'(cif.pkt_valid), 32'd0);
        chk({tag, "_features"},  32'(cif.pkt_features != '0), 32'd0);
        chk({tag, "_led"},       32'(attack_led), 32'd0);
        chk({tag, "_count"},     32'(attack_count), 32'd0);
        chk({tag, "_timeout"},   32'(timeout_err), 32'd0);
        chk({tag, "_hex"},       32'(hex), 32'(hexw(16'h0000)));
    endtask

    // Core model: answers lat cycles after each issue unless silenced.
    initial begin
        cif.core_valid = 1'b0;
        forever begin
            @(posedge clk); #1;
            cif.core_valid = 1'b0;
            if (!rst_n) rsp_cnt = 0;
            else if (cif.pkt_valid) rsp_cnt = core_silent ? 0 : core_lat;
            else if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) cif.core_valid = 1'b1;
            end
        end
    end

    // Scoreboard: every issue must carry the next expected table entry.
    always @(negedge clk) begin
        if (rst_n && cif.pkt_valid) begin
            feat_t e;
            n_issue++;
            last_issue_cyc = cyc;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL issue_unexpected: got issue %0d expected none", n_issue);
            end else begin
                e = exp_q.pop_front();
                if (cif.pkt_features !== e) begin
                    n_fail++;
                    for (int f = 0; f < NF; f++)
                        if (cif.pkt_features[f] !== e[f]) begin
                            $display("FAIL issue_features: issue %0d feat %0d got %h expected %h",
                                     n_issue, f, cif.pkt_features[f], e[f]);
                            break;
                        end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        disp_vec_t dv[4];
        step_vec_t sv[3];
        int base, t0, first;

        dv[0] = '{2'd0, hexw(16'h1234)};
        dv[1] = '{2'd1, hexw(16'hABCD)};
        dv[2] = '{2'd2, hexw(16'h0005)};
        dv[3] = '{2'd3, hexw(16'h0008)};
        sv[0] = '{1'b0, 32'h0000_0042, 32'h0000_0001, 1'b0, 16'd5};
        sv[1] = '{1'b1, 32'h0000_BEEF, 32'h0000_0002, 1'b1, 16'd6};
        sv[2] = '{1'b0, 32'h0000_0F0F, 32'h0000_0003, 1'b0, 16'd6};

        cif.core_attack = 1'b1;
        cif.core_major  = 32'h0000_1234;
        cif.core_minor  = 32'h0000_ABCD;

        repeat (3) @(negedge clk);
        check_reset("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // Continuous mode: latency, idx wrap, attack counting.
        mode = 2'd0; core_lat = 3;
        repeat (5) push_issue();
        @(posedge clk); #1 enable = 1'b1; t0 = cyc;
        wait_issues(1);
        first = last_issue_cyc;
        chk("first_issue_latency", 32'(first - t0), 32'(PER));
        for (int i = 0; i < 300 && attack_count != 16'd4; i++) @(negedge clk);
        chk("count_after_4", 32'(attack_count), 32'd4);
        chk("issues_at_count_4", 32'(n_issue), 32'd4);
        wait_issues(5);
        @(posedge clk); #1 enable = 1'b0;
        wait_idle("cont_idle");
        chk("cont_count", 32'(attack_count), 32'd5);
        chk("cont_issues", 32'(n_issue), 32'd5);

        for (int i = 0; i < 4; i++) begin
            disp_sel = dv[i].sel;
            @(negedge clk);
            chk($sformatf("disp_sel_%0d", i), 32'(hex), 32'(dv[i].exp_hex));
        end
        disp_sel = 2'd0;

        // Single-step with a slow core; the second press lands mid-flight and must be dropped.
        mode = 2'd1; core_lat = 10;
        @(posedge clk); #1 enable = 1'b1;
        base = n_issue;
        for (int i = 0; i < 3; i++) begin
            cif.core_attack = sv[i].atk;
            cif.core_major  = sv[i].maj;
            cif.core_minor  = sv[i].mnr;
            push_issue();
            pulse_step();
            repeat (3) @(posedge clk);
            #1 step = 1'b1;
            @(posedge clk); #1 step = 1'b0;
            wait_idle($sformatf("step_%0d_idle", i));
            chk($sformatf("step_%0d_led", i), 32'(attack_led), 32'(sv[i].exp_led));
            chk($sformatf("step_%0d_count", i), 32'(attack_count), 32'(sv[i].exp_cnt));
            chk($sformatf("step_%0d_hex", i), 32'(hex), 32'(hexw(sv[i].maj[15:0])));
        end
        chk("step_issue_count", 32'(n_issue - base), 32'd3);

        // Timeout with a silent core.
        core_silent = 1'b1;
        base = n_issue;
        push_issue();
        pulse_step();
        wait_issues(base + 1);
        while (cyc < last_issue_cyc + TO) @(negedge clk);
        chk("to_before_err", 32'(timeout_err), 32'd0);
        chk("to_before_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("to_err_set", 32'(timeout_err), 32'd1);
        chk("to_busy_after", 32'(busy), 32'd0);
        chk("to_count_kept", 32'(attack_count), 32'd6);
        chk("to_major_kept", 32'(hex), 32'(hexw(16'h0F0F)));
        disp_sel = 2'd3;
        @(negedge clk);
        chk("to_status", 32'(hex), 32'(hexw(16'h0009)));
        core_silent = 1'b0;

        // Burst from a non-zero idx restarts at entry 0 and stops after the last entry.
        mode = 2'd2; core_lat = 3; cif.core_attack = 1'b1;
        base = n_issue;
        m_idx = 0;
        repeat (NP) push_issue();
        pulse_step();
        wait_issues(base + NP);
        wait_idle("burst_idle");
        chk("burst_issues", 32'(n_issue - base), 32'(NP));
        chk("burst_count", 32'(attack_count), 32'd10);
        chk("burst_status", 32'(hex), 32'(hexw(16'h0001)));

        // Saturation from a preloaded counter.
        mode = 2'd1; disp_sel = 2'd2;
        force dut.attack_count = 16'hFFFE;
        @(posedge clk); #1 release dut.attack_count;
        for (int i = 0; i < 3; i++) begin
            push_issue();
            pulse_step();
            wait_idle($sformatf("sat_%0d_idle", i));
            chk($sformatf("sat_%0d_count", i), 32'(attack_count), 32'hFFFF);
        end
        chk("sat_hex", 32'(hex), 32'(hexw(16'hFFFF)));

        // Reset while a packet is in flight.
        disp_sel = 2'd0; core_silent = 1'b1;
        base = n_issue;
        push_issue();
        pulse_step();
        wait_issues(base + 1);
        repeat (3) @(negedge clk);
        chk("mid_wait_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check_reset("mid_reset");
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
